memory_access_unit: RTL and testbench

Memory-stage engine of the five-stage pipeline, between the EX/MEM and MEM/WB interstage buffers. It takes load/store requests from EX/MEM and runs them on a valid/ready data-memory bus. While an access is outstanding it stalls the pipeline. It returns sign- or zero-extended load data, which feeds the write-back source `wb_memory_data`.

---
 rtl/memory_access_unit_pkg.sv | 49 ++++
 rtl/memory_access_unit_load_aligner.sv | 26 ++
 rtl/memory_access_unit.sv | 158 +++++++++++++++
 tb/tb_memory_access_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_unit_pkg.sv
// Shared definitions for the memory-stage access engine: access size
// encodings, the controller state type and the lane/legality helpers.
package memory_access_package;

    localparam logic [1:0] SIZE_BYTE     = 2'b00;
    localparam logic [1:0] SIZE_HALF     = 2'b01;
    localparam logic [1:0] SIZE_WORD     = 2'b10;
    localparam logic [1:0] SIZE_RESERVED = 2'b11;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_REQUEST,
        STATE_WAIT_RESPONSE,
        STATE_COMPLETE
    } access_state_t;

    // Little-endian byte lanes touched by an access of the given size and offset.
    function automatic logic [3:0] compute_byte_enable(input logic [1:0] size,
                                                       input logic [1:0] offset);
        case (size)
            SIZE_BYTE: return 4'b0001 << offset;
            SIZE_HALF: return 4'b0011 << offset;
            SIZE_WORD: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    // An access is legal when its size is defined and it is naturally aligned.
    function automatic logic is_legal_access(input logic [1:0] size,
                                             input logic [1:0] offset);
        case (size)
            SIZE_BYTE: return 1'b1;
            SIZE_HALF: return ~offset[0];
            SIZE_WORD: return (offset == 2'b00);
            default:   return 1'b0;
        endcase
    endfunction

    // Copies the right-aligned store operand onto every lane it could occupy.
    function automatic logic [31:0] replicate_store_data(input logic [1:0] size,
                                                         input logic [31:0] data);
        case (size)
            SIZE_BYTE: return {4{data[7:0]}};
            SIZE_HALF: return {2{data[15:0]}};
            default:   return data;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_unit_load_aligner.sv
// Combinational load aligner: moves the addressed lane down to bit 0 and
// sign- or zero-extends it to a full word.
module load_aligner
    import memory_access_package::*;
(
    input  logic [31:0] response_data,
    input  logic [1:0]  byte_offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Shift the addressed lane to the bottom, then extend according to size.
    always_comb begin
        shifted   = response_data >> {byte_offset, 3'b000};
        load_data = shifted;
        case (size)
            SIZE_BYTE: load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            default:   load_data = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// Memory-stage engine: runs EX/MEM load/store requests over a valid/ready
// data bus, stalls the pipeline while an access is in flight and returns
// the extended load result for write-back.
module memory_access_unit
    import memory_access_package::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     mem_request_valid,
    input  logic                     mem_request_write,
    input  logic [1:0]               mem_request_size,
    input  logic                     mem_request_signed,
    input  logic [ADDRESS_WIDTH-1:0] mem_address,
    input  logic [31:0]              mem_store_data,
    output logic                     stall,
    output logic [31:0]              load_data,
    output logic                     load_data_valid,
    output logic                     access_fault,
    output logic                     bus_request_valid,
    input  logic                     bus_request_ready,
    output logic                     bus_write,
    output logic [ADDRESS_WIDTH-1:0] bus_address,
    output logic [31:0]              bus_write_data,
    output logic [3:0]               bus_byte_enable,
    input  logic                     bus_response_valid,
    input  logic [31:0]              bus_response_data
);

    localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);

    access_state_t            state_q, state_d;
    logic                     write_q, write_d;
    logic [1:0]               size_q, size_d;
    logic                     signed_q, signed_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [31:0]              store_data_q, store_data_d;
    logic [3:0]               byte_enable_q, byte_enable_d;
    logic [COUNT_WIDTH-1:0]   timeout_count_q, timeout_count_d;
    logic [31:0]              load_data_q, load_data_d;
    logic                     load_valid_q, load_valid_d;
    logic                     timeout_fault_q, timeout_fault_d;
    logic                     illegal_fault;
    logic [31:0]              aligned_data;

    load_aligner u_load_aligner (
        .response_data (bus_response_data),
        .byte_offset   (address_q[1:0]),
        .size          (size_q),
        .is_signed     (signed_q),
        .load_data     (aligned_data)
    );

    // Next-state logic: sequences the bus handshake and drives stall/fault.
    always_comb begin
        state_d         = state_q;
        write_d         = write_q;
        size_d          = size_q;
        signed_d        = signed_q;
        address_d       = address_q;
        store_data_d    = store_data_q;
        byte_enable_d   = byte_enable_q;
        timeout_count_d = timeout_count_q;
        load_data_d     = load_data_q;
        load_valid_d    = 1'b0;
        timeout_fault_d = 1'b0;
        illegal_fault   = 1'b0;
        stall           = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (mem_request_valid) begin
                    if (is_legal_access(mem_request_size, mem_address[1:0])) begin
                        stall         = 1'b1;
                        state_d       = STATE_REQUEST;
                        write_d       = mem_request_write;
                        size_d        = mem_request_size;
                        signed_d      = mem_request_signed;
                        address_d     = mem_address;
                        store_data_d  = replicate_store_data(mem_request_size, mem_store_data);
                        byte_enable_d = compute_byte_enable(mem_request_size, mem_address[1:0]);
                    end else begin
                        illegal_fault = 1'b1;
                    end
                end
            end
            STATE_REQUEST: begin
                stall = 1'b1;
                if (bus_request_ready) begin
                    state_d         = STATE_WAIT_RESPONSE;
                    timeout_count_d = '0;
                end
            end
            STATE_WAIT_RESPONSE: begin
                stall           = 1'b1;
                timeout_count_d = timeout_count_q + 1'b1;
                if (bus_response_valid) begin
                    state_d = STATE_COMPLETE;
                    if (!write_q) begin
                        load_data_d  = aligned_data;
                        load_valid_d = 1'b1;
                    end
                end else if (timeout_count_d == TIMEOUT_LIMIT) begin
                    state_d         = STATE_COMPLETE;
                    timeout_fault_d = 1'b1;
                    load_data_d     = '0;
                end
            end
            STATE_COMPLETE: begin
                state_d = STATE_IDLE;
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    // State and request registers; reset abandons any access in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= STATE_IDLE;
            write_q         <= 1'b0;
            size_q          <= 2'b00;
            signed_q        <= 1'b0;
            address_q       <= '0;
            store_data_q    <= '0;
            byte_enable_q   <= '0;
            timeout_count_q <= '0;
            load_data_q     <= '0;
            load_valid_q    <= 1'b0;
            timeout_fault_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            write_q         <= write_d;
            size_q          <= size_d;
            signed_q        <= signed_d;
            address_q       <= address_d;
            store_data_q    <= store_data_d;
            byte_enable_q   <= byte_enable_d;
            timeout_count_q <= timeout_count_d;
            load_data_q     <= load_data_d;
            load_valid_q    <= load_valid_d;
            timeout_fault_q <= timeout_fault_d;
        end
    end

    assign bus_request_valid = (state_q == STATE_REQUEST);
    assign bus_write         = write_q;
    assign bus_address       = {address_q[ADDRESS_WIDTH-1:2], 2'b00};
    assign bus_write_data    = store_data_q;
    assign bus_byte_enable   = byte_enable_q;
    assign load_data         = load_data_q;
    assign load_data_valid   = load_valid_q;
    assign access_fault      = illegal_fault | timeout_fault_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: a table of single accesses with
// zero bus wait, plus hand-written backpressure, reset and timeout sequences.
module tb_memory_access_unit;

    localparam int AW = 32;
    localparam int TO = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          mem_request_valid = 1'b0;
    logic          mem_request_write = 1'b0;
    logic [1:0]    mem_request_size = 2'b00;
    logic          mem_request_signed = 1'b0;
    logic [AW-1:0] mem_address = '0;
    logic [31:0]   mem_store_data = '0;
    logic          stall;
    logic [31:0]   load_data;
    logic          load_data_valid;
    logic          access_fault;
    logic          bus_request_valid;
    logic          bus_request_ready = 1'b0;
    logic          bus_write;
    logic [AW-1:0] bus_address;
    logic [31:0]   bus_write_data;
    logic [3:0]    bus_byte_enable;
    logic          bus_response_valid = 1'b0;
    logic [31:0]   bus_response_data = '0;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] store_data;
        logic [31:0] response;
        logic        illegal;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
    } vector_t;

    vector_t vectors[12];

    memory_access_unit #(
        .ADDRESS_WIDTH  (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .mem_request_valid  (mem_request_valid),
        .mem_request_write  (mem_request_write),
        .mem_request_size   (mem_request_size),
        .mem_request_signed (mem_request_signed),
        .mem_address        (mem_address),
        .mem_store_data     (mem_store_data),
        .stall              (stall),
        .load_data          (load_data),
        .load_data_valid    (load_data_valid),
        .access_fault       (access_fault),
        .bus_request_valid  (bus_request_valid),
        .bus_request_ready  (bus_request_ready),
        .bus_write          (bus_write),
        .bus_address        (bus_address),
        .bus_write_data     (bus_write_data),
        .bus_byte_enable    (bus_byte_enable),
        .bus_response_valid (bus_response_valid),
        .bus_response_data  (bus_response_data)
    );

    // Free-running 10-unit clock.
    always #5 clock = ~clock;

    // Hard stop in case a sequence never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic write, input logic [1:0] size,
                                 input logic sgn, input logic [31:0] addr,
                                 input logic [31:0] data);
        mem_request_valid  = valid;
        mem_request_write  = write;
        mem_request_size   = size;
        mem_request_signed = sgn;
        mem_address        = addr;
        mem_store_data     = data;
    endtask

    task automatic setBus(input logic ready, input logic resp_valid, input logic [31:0] resp_data);
        bus_request_ready  = ready;
        bus_response_valid = resp_valid;
        bus_response_data  = resp_data;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // One access with ready and response in their earliest cycles (t0..t3).
    task automatic runVector(input vector_t v, input int idx);
        applyStimulus(1'b1, v.write, v.size, v.sgn, v.addr, v.store_data);
        setBus(1'b1, 1'b0, 32'h0);
        @(negedge clock);
        if (v.illegal) begin
            checkOutput($sformatf("v%0d_fault", idx), {31'b0, access_fault}, 32'd1);
            checkOutput($sformatf("v%0d_stall", idx), {31'b0, stall}, 32'd0);
            checkOutput($sformatf("v%0d_req_valid", idx), {31'b0, bus_request_valid}, 32'd0);
            nextCycle();
            applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
            @(negedge clock);
            checkOutput($sformatf("v%0d_idle_req_valid", idx), {31'b0, bus_request_valid}, 32'd0);
            checkOutput($sformatf("v%0d_fault_cleared", idx), {31'b0, access_fault}, 32'd0);
            nextCycle();
        end else begin
            checkOutput($sformatf("v%0d_t0_stall", idx), {31'b0, stall}, 32'd1);
            checkOutput($sformatf("v%0d_t0_fault", idx), {31'b0, access_fault}, 32'd0);
            nextCycle();
            @(negedge clock);
            checkOutput($sformatf("v%0d_t1_req_valid", idx), {31'b0, bus_request_valid}, 32'd1);
            checkOutput($sformatf("v%0d_t1_write", idx), {31'b0, bus_write}, {31'b0, v.write});
            checkOutput($sformatf("v%0d_t1_address", idx), bus_address, v.exp_addr);
            checkOutput($sformatf("v%0d_t1_byte_enable", idx), {28'b0, bus_byte_enable}, {28'b0, v.exp_be});
            checkOutput($sformatf("v%0d_t1_write_data", idx), bus_write_data, v.exp_wdata);
            nextCycle();
            setBus(1'b1, 1'b1, v.response);
            @(negedge clock);
            checkOutput($sformatf("v%0d_t2_stall", idx), {31'b0, stall}, 32'd1);
            checkOutput($sformatf("v%0d_t2_req_valid", idx), {31'b0, bus_request_valid}, 32'd0);
            nextCycle();
            setBus(1'b1, 1'b0, 32'h0);
            @(negedge clock);
            checkOutput($sformatf("v%0d_t3_stall", idx), {31'b0, stall}, 32'd0);
            checkOutput($sformatf("v%0d_t3_load_valid", idx), {31'b0, load_data_valid}, {31'b0, ~v.write});
            checkOutput($sformatf("v%0d_t3_fault", idx), {31'b0, access_fault}, 32'd0);
            if (!v.write)
                checkOutput($sformatf("v%0d_t3_load_data", idx), load_data, v.exp_load);
            nextCycle();
            applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
            @(negedge clock);
            checkOutput($sformatf("v%0d_t4_req_valid", idx), {31'b0, bus_request_valid}, 32'd0);
            checkOutput($sformatf("v%0d_t4_load_valid", idx), {31'b0, load_data_valid}, 32'd0);
            nextCycle();
        end
    endtask

    initial begin
        int      stall_cycles;
        int      waited;
        bit      seen;
        vector_t extra;

        //            wr    size   sgn   addr          store         response      ill   exp_addr      be       wdata         load
        vectors[0]  = '{1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0,        32'h80FF_FF7F, 1'b0, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFF_FF80};
        vectors[1]  = '{1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 32'h0,        1'b0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        vectors[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_1001, 32'h0,        32'h80FF_FF7F, 1'b0, 32'h0000_1000, 4'b0010, 32'h0,        32'h0000_00FF};
        vectors[3]  = '{1'b0, 2'b01, 1'b1, 32'h0000_4002, 32'h0,        32'h8001_1234, 1'b0, 32'h0000_4000, 4'b1100, 32'h0,        32'hFFFF_8001};
        vectors[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_5004, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'h0000_5004, 4'b1111, 32'h0,        32'hDEAD_BEEF};
        vectors[5]  = '{1'b1, 2'b00, 1'b0, 32'h0000_6001, 32'h1234_56A5, 32'h0,        1'b0, 32'h0000_6000, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        vectors[6]  = '{1'b1, 2'b10, 1'b0, 32'h0000_7008, 32'hCAFE_F00D, 32'h0,        1'b0, 32'h0000_7008, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vectors[7]  = '{1'b0, 2'b01, 1'b1, 32'h0000_8000, 32'h0,        32'hABCD_7FFE, 1'b0, 32'h0000_8000, 4'b0011, 32'h0,        32'h0000_7FFE};
        vectors[8]  = '{1'b0, 2'b00, 1'b1, 32'h0000_9002, 32'h0,        32'h00F0_0000, 1'b0, 32'h0000_9000, 4'b0100, 32'h0,        32'hFFFF_FFF0};
        vectors[9]  = '{1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
        vectors[10] = '{1'b0, 2'b01, 1'b0, 32'h0000_3003, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
        vectors[11] = '{1'b0, 2'b11, 1'b0, 32'h0000_3000, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};

        // Reset state
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("reset_stall", {31'b0, stall}, 32'd0);
        checkOutput("reset_req_valid", {31'b0, bus_request_valid}, 32'd0);
        checkOutput("reset_load_data", load_data, 32'h0);
        checkOutput("reset_load_valid", {31'b0, load_data_valid}, 32'd0);
        checkOutput("reset_fault", {31'b0, access_fault}, 32'd0);
        checkOutput("reset_byte_enable", {28'b0, bus_byte_enable}, 32'h0);
        nextCycle();
        reset_n = 1'b1;
        nextCycle();

        // Table of single accesses
        for (int i = 0; i < 12; i++) begin
            runVector(vectors[i], i);
        end

        // Backpressure: ready low 5 cycles, response on the third wait cycle
        stall_cycles = 0;
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'h0);
        setBus(1'b0, 1'b0, 32'h0);
        @(negedge clock);
        if (stall) stall_cycles++;
        nextCycle();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 2'b10, 1'b1, 32'hFFFF_FFF1 + i, 32'h5555_5555);
            @(negedge clock);
            if (stall) stall_cycles++;
            checkOutput($sformatf("bp_req_valid_%0d", i), {31'b0, bus_request_valid}, 32'd1);
            checkOutput($sformatf("bp_address_%0d", i), bus_address, 32'h0);
            checkOutput($sformatf("bp_byte_enable_%0d", i), {28'b0, bus_byte_enable}, 32'h3);
            checkOutput($sformatf("bp_write_%0d", i), {31'b0, bus_write}, 32'd0);
            nextCycle();
        end
        setBus(1'b1, 1'b0, 32'h0);
        @(negedge clock);
        if (stall) stall_cycles++;
        checkOutput("bp_handshake_req_valid", {31'b0, bus_request_valid}, 32'd1);
        nextCycle();
        setBus(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            if (stall) stall_cycles++;
            checkOutput($sformatf("bp_wait_req_valid_%0d", i), {31'b0, bus_request_valid}, 32'd0);
            nextCycle();
        end
        setBus(1'b0, 1'b1, 32'h1234_8001);
        @(negedge clock);
        if (stall) stall_cycles++;
        nextCycle();
        setBus(1'b0, 1'b0, 32'h0);
        @(negedge clock);
        checkOutput("bp_complete_stall", {31'b0, stall}, 32'd0);
        checkOutput("bp_load_valid", {31'b0, load_data_valid}, 32'd1);
        checkOutput("bp_load_data", load_data, 32'h0000_8001);
        checkOutput("bp_stall_cycles", 32'(stall_cycles), 32'd10);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        nextCycle();

        // Reset while waiting for a response
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_A000, 32'h0);
        setBus(1'b1, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        setBus(1'b0, 1'b0, 32'h0);
        nextCycle();
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("rst_stall", {31'b0, stall}, 32'd0);
        checkOutput("rst_req_valid", {31'b0, bus_request_valid}, 32'd0);
        checkOutput("rst_address", bus_address, 32'h0);
        checkOutput("rst_byte_enable", {28'b0, bus_byte_enable}, 32'h0);
        checkOutput("rst_load_data", load_data, 32'h0);
        checkOutput("rst_load_valid", {31'b0, load_data_valid}, 32'd0);
        checkOutput("rst_fault", {31'b0, access_fault}, 32'd0);
        nextCycle();
        extra = '{1'b0, 2'b10, 1'b1, 32'h0000_B000, 32'h0, 32'h1357_9BDF, 1'b0,
                  32'h0000_B000, 4'b1111, 32'h0, 32'h1357_9BDF};
        runVector(extra, 100);

        // Timeout with no response, then a late response that must be dropped
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_C000, 32'h0);
        setBus(1'b1, 1'b0, 32'h0);
        nextCycle();
        @(negedge clock);
        checkOutput("to_req_valid", {31'b0, bus_request_valid}, 32'd1);
        nextCycle();
        setBus(1'b0, 1'b0, 32'h0);
        waited = 0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clock);
            if (access_fault) begin
                seen = 1'b1;
            end else begin
                checkOutput($sformatf("to_wait_stall_%0d", c), {31'b0, stall}, 32'd1);
                waited++;
                nextCycle();
            end
        end
        checkOutput("to_fault_seen", {31'b0, seen}, 32'd1);
        checkOutput("to_wait_cycles", 32'(waited), 32'd4);
        checkOutput("to_load_data", load_data, 32'h0);
        checkOutput("to_load_valid", {31'b0, load_data_valid}, 32'd0);
        checkOutput("to_stall", {31'b0, stall}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        setBus(1'b0, 1'b1, 32'hFFFF_FFFF);
        @(negedge clock);
        checkOutput("late_load_valid", {31'b0, load_data_valid}, 32'd0);
        checkOutput("late_fault", {31'b0, access_fault}, 32'd0);
        checkOutput("late_stall", {31'b0, stall}, 32'd0);
        checkOutput("late_req_valid", {31'b0, bus_request_valid}, 32'd0);
        nextCycle();
        setBus(1'b0, 1'b0, 32'h0);
        @(negedge clock);
        checkOutput("late_load_valid_after", {31'b0, load_data_valid}, 32'd0);
        checkOutput("late_load_data_after", load_data, 32'h0);
        nextCycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
